muldiv_seq: RTL and testbench

- Iterative RV32M execute helper for MUL (low word), DIVU and REMU.
- Drives the shared execute-stage ALU as an initiator: one ALU operation per cycle, combinational result consumed the same cycle.
- Sits beside the ALU in the execute stage. The pipeline stalls while busy is high.
- ALU Ctrl encodings come from header/macro.vh (`ADD, `SUB).

---
 rtl/muldiv_seq_if.sv | 30 +++
 rtl/muldiv_seq.sv | 178 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response and shared-ALU signals between muldiv_seq and the execute stage.
// slave is the muldiv unit; master is the pipeline plus the ALU it borrows.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            kill;
  logic            ready;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_out;
  logic            alu_sltu;

  modport slave (
    input  start, op, opa, opb, kill, alu_out, alu_sltu,
    output ready, busy, valid, result, alu_ctrl, alu_a, alu_b
  );

  modport master (
    output start, op, opa, opb, kill, alu_out, alu_sltu,
    input  ready, busy, valid, result, alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/DIVU/REMU unit that borrows the execute-stage ALU for one
// add or subtract per cycle; shift-add multiply and restoring divide, 32 iterations.
module muldiv_seq #(
  parameter int         XLEN    = 32,
  parameter int         ITER    = 32,
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ILL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  op_t             op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] result_q;
  logic            valid_q;

  logic            accept;
  logic            last;
  logic            is_div;
  logic [XLEN-1:0] shifted;
  logic            carry;
  logic            take;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] res_sel;

  assign accept = bus.start && !bus.kill && (state == S_IDLE);
  assign last   = (cnt == CW'(ITER - 1));
  assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

  // Divide step: shift the next dividend bit into the partial remainder. The
  // bit shifted out of rem is the 33rd bit; when set, s - opb cannot go negative.
  assign shifted = {rem[XLEN-2:0], quo[XLEN-1]};
  assign carry   = rem[XLEN-1];
  assign take    = carry || !bus.alu_sltu;
  assign rem_nxt = take ? bus.alu_out : shifted;
  assign quo_nxt = {quo[XLEN-2:0], take};
  assign acc_nxt = mplier[0] ? bus.alu_out : acc;

  always_comb begin
    unique case (op_q)
      OP_DIVU: res_sel = quo_nxt;
      OP_REMU: res_sel = rem_nxt;
      default: res_sel = acc_nxt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (op_t'(bus.op) == OP_ILL) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.kill) begin
          state_nxt = S_IDLE;
        end else if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The ALU is driven only in RUN, so it stays quiet otherwise.
  always_comb begin
    bus.alu_ctrl = ALU_ADD;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    if (state == S_RUN) begin
      if (is_div) begin
        bus.alu_ctrl = ALU_SUB;
        bus.alu_a    = shifted;
        bus.alu_b    = opb_q;
      end else begin
        bus.alu_ctrl = ALU_ADD;
        bus.alu_a    = acc;
        bus.alu_b    = mcand;
      end
    end
  end

  assign bus.ready  = (state == S_IDLE);
  assign bus.busy   = (state != S_IDLE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

  // NOTE: datapath registers are reset as well, so no X can reach an output
  // or the shared ALU after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      cnt      <= '0;
      opb_q    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= (state == S_DONE) && !bus.kill;
      if (accept) begin
        op_q   <= op_t'(bus.op);
        opb_q  <= bus.opb;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= bus.opa;
        mplier <= bus.opb;
        rem    <= '0;
        quo    <= bus.opa;
        if (op_t'(bus.op) == OP_ILL) begin
          result_q <= '0;
        end
      end else if ((state == S_RUN) && !bus.kill) begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          rem <= rem_nxt;
          quo <= quo_nxt;
        end else begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        if (last) begin
          result_q <= res_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops,
// with a simple arithmetic reference model and a behavioural ALU.
module tb_muldiv_seq;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [1:0] MUL  = 2'b00;
  localparam logic [1:0] ILL  = 2'b01;
  localparam logic [1:0] DIVU = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(
    .XLEN   (32),
    .ITER   (32),
    .ALU_ADD(ALU_ADD),
    .ALU_SUB(ALU_SUB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared execute-stage ALU seen by the unit.
  always_comb begin
    bus.alu_out  = (bus.alu_ctrl == ALU_SUB) ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);
    bus.alu_sltu = (bus.alu_a < bus.alu_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      MUL:     return a * b;
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU:    return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Issue one op from a negedge where ready is high; returns at the negedge of the valid cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          exp_lat;
    int          cyc;
    bit          saw_ready;
    exp     = model(o, a, b);
    exp_lat = (o == ILL) ? 1 : 33;
    check({tag, "_ready_pre"}, bus.ready, 1);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.opa   = $urandom;
    bus.opb   = $urandom;
    check({tag, "_busy_c0"}, bus.busy, 1);
    check({tag, "_valid_c0"}, bus.valid, 0);
    cyc       = 0;
    saw_ready = 1'b0;
    while (!bus.valid && cyc < 60) begin
      if (bus.ready) saw_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_ready_low_run"}, saw_ready, 0);
    check({tag, "_ready_at_valid"}, bus.ready, 1);
    check({tag, "_alu_quiet"}, {bus.alu_a | bus.alu_b, 29'h0, bus.alu_ctrl} == {32'h0, 29'h0, ALU_ADD}, 1);
  endtask

  initial begin
    logic [31:0] prev;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          saw;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = MUL;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_alu_ctrl", bus.alu_ctrl, ALU_ADD);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MUL, 32'd7, 32'd6, "mul_7x6");
    @(negedge clk);
    check("mul_valid_one_cycle", bus.valid, 0);
    run_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
    run_op(MUL, 32'h0001_0000, 32'h0001_0000, "mul_wrap");
    run_op(DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(REMU, 32'd100, 32'd7, "remu_100_7");
    run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_carry");
    run_op(REMU, 32'hFFFF_FFFF, 32'h8000_0001, "remu_carry");
    run_op(DIVU, 32'd1234, 32'd0, "divu_by0");
    run_op(REMU, 32'd1234, 32'd0, "remu_by0");
    run_op(ILL, 32'd55, 32'd3, "illegal");
    @(negedge clk);

    // Kill mid-RUN: no valid, result unchanged.
    prev = bus.result;
    bus.start = 1'b1; bus.op = DIVU; bus.opa = 32'd999; bus.opb = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_run_ready", bus.ready, 1);
    check("kill_run_valid", bus.valid, 0);
    check("kill_run_result", bus.result, prev);
    saw = 1'b0;
    repeat (40) begin
      if (bus.valid) saw = 1'b1;
      @(negedge clk);
    end
    check("kill_run_no_valid", saw, 0);

    // Start with kill in IDLE is not accepted.
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = MUL; bus.opa = 32'd3; bus.opb = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    check("kill_idle_ready", bus.ready, 1);
    check("kill_idle_busy", bus.busy, 0);

    // Kill in DONE suppresses the valid pulse.
    bus.start = 1'b1; bus.op = ILL;
    @(negedge clk);
    bus.start = 1'b0;
    check("kill_done_busy", bus.busy, 1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_done_valid", bus.valid, 0);
    check("kill_done_ready", bus.ready, 1);

    // Randomized ops against the reference model, issued back to back.
    run_op(MUL, 32'd9, 32'd9, "pre_rand");
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = $urandom | 32'h8000_0000;
        2:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MUL; bus.opa = 32'd11; bus.opb = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", bus.ready, 1);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_result", bus.result, 0);
    check("rst_mid_valid", bus.valid, 0);
    check("rst_mid_alu_a", bus.alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(REMU, 32'd12345, 32'd100, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
